// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and constants for timer_chain
package timer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [31:0] DEF_MODS = 32'h0000AA6A;
    localparam int ADD_DIGIT = 1;
    localparam logic [3:0] ADD_INC = 4'd3;
endpackage

// File: rtl/timer_digit.sv
// timer_digit: one modulo-MOD down-counting digit; TIMER_CHAIN_ADD30_EN adds the increment path
module timer_digit
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec_in,
    output logic       borrow_out,
`ifdef TIMER_CHAIN_ADD30_EN
    input  logic       inc,
    input  logic       sat,
    input  logic [3:0] inc_val,
    input  logic       carry_in,
    output logic       carry_gen,
    output logic       carry_prop,
`endif
    output logic [3:0] q
);
    localparam logic [4:0] MODV = 5'(MOD);
    localparam logic [4:0] MODM1 = 5'(MOD - 1);
    localparam logic [3:0] MAXV = 4'(MOD - 1);
    logic [3:0] q_d, q_q;
`ifdef TIMER_CHAIN_ADD30_EN
    logic [4:0] inc_sum, sum;
`endif
    // borrow/carry are exported as lookahead terms so the chain resolves in the parent
    always_comb begin
        borrow_out = q_q == 4'd0;
`ifdef TIMER_CHAIN_ADD30_EN
        inc_sum = {1'b0, q_q} + {1'b0, inc_val};
        sum = inc_sum + {4'd0, carry_in};
        carry_gen = inc_sum >= MODV;
        carry_prop = inc_sum == MODM1;
`endif
        q_d = q_q;
        if (clear) q_d = 4'd0;
        else if (load) q_d = {1'b0, load_val} >= MODV ? MAXV : load_val;
`ifdef TIMER_CHAIN_ADD30_EN
        else if (sat) q_d = MAXV;
        else if (inc) q_d = sum >= MODV ? 4'(sum - MODV) : sum[3:0];
`endif
        else if (dec_in) q_d = borrow_out ? MAXV : q_q - 4'd1;
    end
    always_ff @(posedge clk) q_q <= clr ? 4'd0 : q_d;
    assign q = q_q;
endmodule

// File: rtl/timer_chain.sv
// timer_chain: cascaded mixed-radix countdown with IDLE/RUN/PAUSE/DONE control; TIMER_CHAIN_ADD30_EN enables add-30
module timer_chain
    import timer_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter logic [31:0] MODS       = DEF_MODS
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic                    loadn,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    cancel,
    input  logic                    add30,
    output logic [4*NUM_DIGITS-1:0] out,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);
    localparam int W = 4 * NUM_DIGITS;
    state_t state_d, state_q;
    logic done_d, done_q;
    logic act, hold, last, do_cancel, do_load, do_add, do_pause, do_start, do_tick;
    logic [NUM_DIGITS-1:0] bz, dec;
    logic unused_ok;
`ifdef TIMER_CHAIN_ADD30_EN
    logic [NUM_DIGITS-1:0] gen, prop;
    logic [NUM_DIGITS:0] cy;
    logic sat;
    assign unused_ok = bz[NUM_DIGITS-1];
`else
    assign unused_ok = ^{bz[NUM_DIGITS-1], add30};
`endif
    assign zero = out == '0;
    assign last = out == W'(1);
    assign running = state_q == RUN;
    assign done = done_q;
    // each enable is masked by every higher-priority request that applies in this state
    always_comb begin
        act = state_q != DONE;
        do_cancel = act & cancel;
        do_load = !do_cancel & !loadn & (state_q == IDLE | state_q == PAUSE);
`ifdef TIMER_CHAIN_ADD30_EN
        do_add = !do_cancel & !do_load & act & add30;
`else
        do_add = 1'b0;
`endif
        hold = do_cancel | do_load | do_add;
        do_pause = !hold & pause & (state_q == RUN);
        do_start = !hold & start & ((state_q == IDLE & !zero) | state_q == PAUSE);
        do_tick = !hold & !do_pause & tick & (state_q == RUN);
        state_d = !act ? IDLE :
                  do_cancel ? IDLE :
                  (do_add & state_q == IDLE & zero) ? RUN :
                  do_pause ? PAUSE :
                  do_start ? RUN :
                  (do_tick & last) ? DONE : state_q;
        done_d = do_tick & last;
    end
    always_comb begin
        dec[0] = do_tick;
        for (int k = 1; k < NUM_DIGITS; k++) dec[k] = dec[k-1] & bz[k-1];
    end
`ifdef TIMER_CHAIN_ADD30_EN
    always_comb begin
        cy[0] = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) cy[k+1] = gen[k] | (prop[k] & cy[k]);
    end
    assign sat = do_add & cy[NUM_DIGITS];
`endif
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        timer_digit #(.MOD(int'(MODS[4*i +: 4]))) u_dig (
            .clk        (clk),
            .clr        (clr),
            .clear      (do_cancel),
            .load       (do_load),
            .load_val   (data[4*i +: 4]),
            .dec_in     (dec[i]),
            .borrow_out (bz[i]),
`ifdef TIMER_CHAIN_ADD30_EN
            .inc        (do_add),
            .sat        (sat),
            .inc_val    (i == ADD_DIGIT ? ADD_INC : 4'd0),
            .carry_in   (cy[i]),
            .carry_gen  (gen[i]),
            .carry_prop (prop[i]),
`endif
            .q          (out[4*i +: 4])
        );
    end
    always_ff @(posedge clk) begin
        state_q <= clr ? IDLE : state_d;
        done_q <= !clr & done_d;
    end
endmodule

// File: tb/tb_timer_chain.sv
// tb_timer_chain: directed scenarios plus randomized run against a mixed-radix integer model
module tb_timer_chain;
    logic clk = 1'b0;
    logic clr = 1'b1, loadn = 1'b1, tick = 1'b0, start = 1'b0, pause = 1'b0, cancel = 1'b0, add30 = 1'b0;
    logic [15:0] data = '0, out;
    logic zero, running, done;
    logic [18:0] obs;
    int tests = 0, fails = 0;
    int mods[4] = '{10, 6, 10, 10};
    localparam int TOTAL = 6000;
`ifdef TIMER_CHAIN_ADD30_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    int mval = 0;
    mstate_t mst = M_IDLE;
    bit mdone = 1'b0;

    timer_chain dut (
        .clk(clk), .clr(clr), .data(data), .loadn(loadn), .tick(tick), .start(start),
        .pause(pause), .cancel(cancel), .add30(add30), .out(out), .zero(zero),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;
    assign obs = {out, zero, running, done};

    function automatic int to_val(input logic [15:0] d);
        int v, dv;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            dv = int'(d[4*i +: 4]);
            v = v * mods[i] + (dv >= mods[i] ? mods[i] - 1 : dv);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % mods[i]);
            v = v / mods[i];
        end
        return r;
    endfunction

    function automatic logic [18:0] expv();
        return {to_bcd(mval), mval == 0, mst == M_RUN, mdone};
    endfunction

    task automatic step(input logic c, lo, tk, st, pa, ca, a3, input logic [15:0] d);
        clr = c; loadn = !lo; tick = tk; start = st; pause = pa; cancel = ca; add30 = a3; data = d;
        if (c) begin
            mval = 0; mst = M_IDLE; mdone = 1'b0;
        end else if (mst == M_DONE) begin
            mst = M_IDLE; mdone = 1'b0;
        end else begin
            mdone = 1'b0;
            if (ca) begin
                mval = 0; mst = M_IDLE;
            end else if (lo && mst != M_RUN) mval = to_val(d);
            else if (ADD && a3) begin
                if (mst == M_IDLE && mval == 0) mst = M_RUN;
                mval = mval + 3 * mods[0] > TOTAL - 1 ? TOTAL - 1 : mval + 3 * mods[0];
            end else if (pa && mst == M_RUN) mst = M_PAUSE;
            else if (st && ((mst == M_IDLE && mval != 0) || mst == M_PAUSE)) mst = M_RUN;
            else if (tk && mst == M_RUN) begin
                if (mval == 1) begin
                    mval = 0; mst = M_DONE; mdone = 1'b1;
                end else mval = (mval + TOTAL - 1) % TOTAL;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 16'h0);
        step(1, 0, 1, 1, 0, 0, 0, 16'h1234);
        tests++;
        if (obs !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset: got %h want %h", obs, {16'h0000, 1'b1, 1'b0, 1'b0});
        end
        step(0, 0, 0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic test_countdown();
        int nd = 0;
        step(0, 1, 0, 0, 0, 0, 0, 16'h0130);
        tests++;
        if (out !== 16'h0130) begin fails++; $display("FAIL cd_load: got %h want 0130", out); end
        step(0, 0, 0, 1, 0, 0, 0, 16'h0);
        tests++;
        if (running !== 1'b1) begin fails++; $display("FAIL cd_start: running %b want 1", running); end
        for (int t = 1; t <= 90; t++) begin
            step(0, 0, 1, 0, 0, 0, 0, 16'h0);
            nd += int'(done);
            tests++;
            if (obs !== expv()) begin fails++; $display("FAIL cd_tick%0d: got %h want %h", t, obs, expv()); end
            if (t == 1) begin
                tests++;
                if (out !== 16'h0129) begin fails++; $display("FAIL cd_first: got %h want 0129", out); end
            end
            if (t == 31) begin
                tests++;
                if (out !== 16'h0059) begin fails++; $display("FAIL cd_wrap: got %h want 0059", out); end
            end
        end
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL cd_done: got %b want 1", done); end
        step(0, 0, 1, 1, 0, 0, 0, 16'h0);
        nd += int'(done);
        tests++;
        if (obs !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin fails++; $display("FAIL cd_idle: got %h want %h", obs, {16'h0000, 1'b1, 1'b0, 1'b0}); end
        tests++;
        if (nd != 1) begin fails++; $display("FAIL cd_pulses: got %0d want 1", nd); end
    endtask

    task automatic test_zero_start();
        int nd = 0;
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        for (int n = 0; n < 4; n++) begin
            step(0, 0, 1, 1, 0, 0, 0, 16'h0);
            nd += int'(done);
        end
        tests++;
        if (obs !== {16'h0000, 1'b1, 1'b0, 1'b0} || nd != 0) begin
            fails++; $display("FAIL zero_start: got %h done_pulses %0d want %h 0", obs, nd, {16'h0000, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_pause_tick();
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 16'h0105);
        step(0, 0, 0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 1, 0, 0, 0, 16'h0);
        tests++;
        if ({out, running} !== {16'h0105, 1'b1}) begin fails++; $display("FAIL pt_run: got %h/%b want 0105/1", out, running); end
        step(0, 0, 1, 0, 1, 0, 0, 16'h0);
        tests++;
        if ({out, running} !== {16'h0105, 1'b0} || obs !== expv()) begin
            fails++; $display("FAIL pt_pause: got %h want %h", obs, expv());
        end
        step(0, 0, 1, 0, 0, 0, 0, 16'h0);
        tests++;
        if ({out, running} !== {16'h0105, 1'b0}) begin fails++; $display("FAIL pt_ignore: got %h/%b want 0105/0", out, running); end
        step(0, 0, 0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 1, 0, 0, 0, 0, 16'h0);
        tests++;
        if ({out, running} !== {16'h0104, 1'b1}) begin fails++; $display("FAIL pt_resume: got %h/%b want 0104/1", out, running); end
    endtask

    task automatic test_clamp();
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 16'h97F9);
        tests++;
        if (out !== 16'h9759 || obs !== expv()) begin fails++; $display("FAIL clamp: got %h want 9759", out); end
    endtask

    task automatic test_clr_run();
        int nd = 0;
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 16'h0002);
        step(0, 0, 1, 1, 0, 0, 0, 16'h0);
        step(1, 0, 1, 0, 0, 0, 0, 16'h0);
        nd += int'(done);
        tests++;
        if (obs !== {16'h0000, 1'b1, 1'b0, 1'b0}) begin fails++; $display("FAIL clr_run: got %h want %h", obs, {16'h0000, 1'b1, 1'b0, 1'b0}); end
        for (int n = 0; n < 3; n++) begin
            step(0, 0, 1, 0, 0, 0, 0, 16'h0);
            nd += int'(done);
        end
        tests++;
        if (nd != 0) begin fails++; $display("FAIL clr_nodone: got %0d pulses want 0", nd); end
    endtask

    task automatic test_add30();
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 1, 0, 0, 0, 0, 0, 16'h0045);
        step(0, 0, 0, 1, 0, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 1, 16'h0);
        tests++;
        if (out !== (ADD ? 16'h0115 : 16'h0045) || running !== 1'b0) begin
            fails++; $display("FAIL add_carry: got %h/%b want %h/0", out, running, ADD ? 16'h0115 : 16'h0045);
        end
        step(0, 1, 0, 0, 0, 0, 0, 16'h9950);
        step(0, 0, 0, 0, 0, 0, 1, 16'h0);
        tests++;
        if (out !== (ADD ? 16'h9959 : 16'h9950)) begin fails++; $display("FAIL add_sat: got %h want %h", out, ADD ? 16'h9959 : 16'h9950); end
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 1, 16'h0);
        tests++;
        if ({out, running} !== (ADD ? {16'h0030, 1'b1} : {16'h0000, 1'b0})) begin
            fails++; $display("FAIL add_quick: got %h/%b want %h", out, running, ADD ? {16'h0030, 1'b1} : {16'h0000, 1'b0});
        end
        step(0, 0, 0, 0, 0, 1, 0, 16'h0);
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int n = 0; n < 4000; n++) begin
            d = $urandom_range(0, 1) ? 16'($urandom_range(0, 16'h0030)) : 16'($urandom);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 29) == 0, d);
            tests++;
            if (obs !== expv()) begin fails++; $display("FAIL random%0d: got %h want %h", n, obs, expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_zero_start();
        test_pause_tick();
        test_clamp();
        test_clr_run();
        test_add30();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
